// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// State codes are exported so the bench can recognise the DONE cycle.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the serial subtractor: the requester drives start/a/b,
// the subtractor answers with busy/done and a held result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the column needs a borrow.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first through a single full_subtractor cell.
// Result and borrow are published only when the last bit has been computed.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             bw_q, bw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fs_d, fs_bout;

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bw_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    bw_d     = bw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new start directly so back-to-back ops lose no cycle
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        d_sh_d = (d_sh_q >> 1) | {fs_d, {(WIDTH-1){1'b0}}};
        bw_d   = fs_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          diff_d   = d_sh_d;
          borrow_d = fs_bout;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      bw_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      bw_q     <= bw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed table, handshake corner cases, random ops
// on an 8-bit instance and an exhaustive sweep on a 4-bit instance.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(4)) if4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bw;
  } vec_t;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] held_d8 = '0;
  logic       held_b8 = 1'b0;
  logic [3:0] held_d4 = '0;
  logic       held_b4 = 1'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts an op in the current cycle (DUT in IDLE or DONE); returns in the DONE cycle.
  // inj>0 pulses a competing start with 00/01 during RUN cycle inj.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int inj, input string tag);
    logic [8:0] r;
    logic       lat_ok;
    r = {1'b0, a} - {1'b0, b};
    lat_ok = 1'b1;
    if8.start = 1'b1; if8.a = a; if8.b = b;
    for (int c = 1; c <= 8; c++) begin
      tick;
      lat_ok = lat_ok & (if8.busy === 1'b1) & (if8.done === 1'b0)
                      & (if8.diff === held_d8) & (if8.borrow_out === held_b8);
      if8.start = (c == inj) && (c < 8);
      if8.a = (c == inj) ? 8'h00 : 8'($urandom);
      if8.b = (c == inj) ? 8'h01 : 8'($urandom);
    end
    tick;
    check({tag, "_lat"}, 32'(lat_ok), 32'd1);
    check({tag, "_done"}, {if8.done, if8.busy}, 2'b10);
    check({tag, "_diff"}, if8.diff, r[7:0]);
    check({tag, "_bw"}, if8.borrow_out, r[8]);
    held_d8 = r[7:0];
    held_b8 = r[8];
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    logic       lat_ok;
    r = {1'b0, a} - {1'b0, b};
    lat_ok = 1'b1;
    if4.start = 1'b1; if4.a = a; if4.b = b;
    for (int c = 1; c <= 4; c++) begin
      tick;
      lat_ok = lat_ok & (if4.busy === 1'b1) & (if4.done === 1'b0) & (if4.diff === held_d4);
      if4.start = 1'b0;
      if4.a = 4'($urandom);
      if4.b = 4'($urandom);
    end
    tick;
    check("w4_lat", 32'(lat_ok & if4.done & ~if4.busy), 32'd1);
    check("w4_result", {if4.borrow_out, if4.diff}, r);
    held_d4 = r[3:0];
    held_b4 = r[4];
    tick;
    check("w4_pulse", if4.done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[8];
    logic seen_done;
    vt[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
    vt[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
    vt[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
    vt[4] = '{8'h01, 8'h02, 8'hFF, 1'b1};
    vt[5] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vt[6] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vt[7] = '{8'hFF, 8'hFF, 8'h00, 1'b0};

    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0;
    rst_n = 1'b0;
    tick; tick;
    check("rst8", {if8.busy, if8.done, if8.borrow_out, if8.diff}, 11'd0);
    check("rst4", {if4.busy, if4.done, if4.borrow_out, if4.diff}, 7'd0);
    check("rst_state", 32'(dut8.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick;

    // directed table
    for (int i = 0; i < 8; i++) begin
      op8(vt[i].a, vt[i].b, 0, "vec");
      check("vec_table", {if8.borrow_out, if8.diff}, {vt[i].bw, vt[i].d});
      tick;
      check("vec_pulse", {if8.done, if8.busy}, 2'b00);
    end

    // start while busy is ignored
    op8(8'hFF, 8'h01, 2, "ignore");
    tick;
    check("ignore_idle", {if8.done, if8.busy}, 2'b00);
    check("ignore_hold", {if8.borrow_out, if8.diff}, 9'h0FE);

    // back-to-back from DONE
    op8(8'hFF, 8'h01, 0, "b2b1");
    check("b2b_state", 32'(dut8.state_q), 32'(ST_DONE));
    op8(8'h01, 8'h02, 0, "b2b2");
    check("b2b_final", {if8.borrow_out, if8.diff}, 9'h1FF);
    tick;

    // reset in the 4th RUN cycle aborts the op
    if8.start = 1'b1; if8.a = 8'h5A; if8.b = 8'h23;
    tick;
    if8.start = 1'b0;
    tick; tick; tick;
    check("abort_busy", if8.busy, 1'b1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("abort_clr", {if8.busy, if8.done, if8.borrow_out, if8.diff}, 11'd0);
    check("abort_state", 32'(dut8.state_q), 32'(ST_IDLE));
    held_d8 = '0; held_b8 = 1'b0;
    held_d4 = '0; held_b4 = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick;
      seen_done = seen_done | if8.done | if8.busy;
    end
    check("abort_nodone", seen_done, 1'b0);

    // random ops, randomly chained back-to-back
    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), 0, "rand");
      if ($urandom_range(1, 0) == 1) begin
        tick;
        check("rand_pulse", if8.done, 1'b0);
      end
    end
    if8.start = 1'b0;
    tick;

    // exhaustive 4-bit sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op4(4'(a), 4'(b));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
